reservation_station: RTL
========================

# reservation_station

Dual-dispatch reservation station that sits directly downstream of the renaming register file. It holds DEPTH instructions whose source operands arrive either as 32-bit data or as 8-bit producer tags, and snoops the 4-lane CDB to resolve pending tags. It hands ready instructions to one functional unit through a valid/ready handshake. It also supplies the destination tags that the arbiter passes to the register file as rd_tag_A/rd_tag_B.

## Interface
- DEPTH, 4: number of entries, 2..8.
- STATION_ID, 1: upper 5 tag bits, 1..31. Tag 0 is reserved for "no tag".
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- en  in  1  global advance. When 0, all state is frozen.
- disp_valid_A / disp_valid_B  in  1  dispatch request, ports A and B.
- disp_op_A / disp_op_B  in  4  opcode.
- disp_v1_A, disp_v2_A / disp_v1_B, disp_v2_B  in  32  operand value, or tag in bits [7:0].
- disp_t1_A, disp_t2_A / disp_t1_B, disp_t2_B  in  1  operand type: 0 = data, 1 = tag.
- alloc_tag_A / alloc_tag_B  out  8  tag that a dispatch on that port will occupy.
- alloc_ok_A / alloc_ok_B  out  1  at least 1 (A) or 2 (B) entries are FREE.
- CDB_data_serialized  in  128  4 × 32-bit lanes. Lane 0 occupies the MSBs.
- CDB_tag_serialized  in  32  4 × 8-bit lanes. Lane 0 occupies the MSBs. Tag 0 means the lane is idle.
- issue_valid  out  1  a READY entry is presented.
- issue_ready  in  1  the functional unit accepts.
- issue_op  out  4; issue_src1 / issue_src2  out  32; issue_tag  out  8.

## Operation
- Tag encoding: tag = {STATION_ID[4:0], entry_index[2:0]}.
- Per-entry states:
  - FREE → WAIT: on dispatch when either operand is still a tag.
  - FREE → READY: on dispatch when both operands are data.
  - WAIT → READY: when the last pending tag is captured.
  - READY → ISSUED: on issue handshake.
  - ISSUED → FREE: when the entry's own tag appears on any CDB lane.
- Allocation is combinational from current state:
  - alloc_tag_A is the lowest-index FREE entry.
  - alloc_tag_B is the second-lowest FREE entry, even when A is not dispatching.
  - When there are too few FREE entries, the tag outputs hold the base tag ({STATION_ID, 3'd0}).
- Dispatch when the matching alloc_ok is 0 is ignored. No state changes.
- CDB capture, for every WAIT operand whose tag equals a lane tag (nonzero):
  - The lane data is latched and the operand becomes data.
  - If multiple lanes match, the highest lane index wins.
- Same-cycle forwarding: a dispatched tag operand that matches a CDB lane in the dispatch cycle is stored as data.
- Issue selection:
  - The lowest-index READY entry is presented combinationally.
  - The handshake is issue_valid && issue_ready && en.
  - issue_valid is forced to 0 when en = 0.
- An entry freeing in cycle N is not visible to allocation until N+1.

## Timing
- Reset values:
  - All entries FREE; operands cleared.
  - issue_valid = 0; issue_op, issue_src1, issue_src2 = 0; issue_tag = base tag.
  - alloc_ok_A = alloc_ok_B = 1; alloc_tag_A = base tag + 0, alloc_tag_B = base tag + 1.
- Dispatch with two data operands at edge N gives issue_valid in cycle N+1 (1-cycle latency).
- A CDB match at edge N gives READY at N+1, and issue is possible in cycle N+1.
- Handshake at edge N gives ISSUED from N+1; the next READY entry is presented in N+1.
- Reset asserted mid-operation clears all entries immediately, without waiting for clk. In-flight results for old tags are ignored afterwards.

## Structure
- Shared package tomasulo_pkg:
  - Constants TAG_W = 8, DATA_W = 32, CDB_LANES = 4, OP_W = 4.
  - rs_state_t enum {FREE, WAIT, READY, ISSUED}.
  - Function cdb_unpack for the serialized buses, to be reused by the register file and other stations.
- Sub-module rs_priority_pick: parameterised lowest-set-bit finder returning index and found flag. It is instantiated for FREE (twice: first, then second with the first masked out) and for READY.

## Test plan
- Reset with STATION_ID = 1, DEPTH = 4 → alloc_tag_A = 0x08, alloc_tag_B = 0x09, both alloc_ok = 1, issue_valid = 0.
- Dispatch A with op = 3, v1 = 5, v2 = 7 (data), issue_ready = 1 → next cycle issue_valid = 1, issue_src1 = 5, issue_src2 = 7, issue_tag = 0x08. The cycle after, issue_valid = 0.
- Dispatch A with src1 = tag 0x21 → entry stays WAIT. Then CDB lane 2 carries 0x21 / 0xDEADBEEF → next cycle issue_src1 = 0xDEADBEEF.
- Dispatch with src2 = tag 0x22 while CDB lane 0 carries 0x22 / 0x1234 in the same cycle → next cycle issue_valid = 1, issue_src2 = 0x1234.
- Fill all 4 entries → alloc_ok_A = 0, and a further dispatch is ignored. After issuing 0x08, CDB tag 0x08 → next cycle alloc_tag_A = 0x08, alloc_ok_A = 1.
- en = 0 while a matching CDB tag and a dispatch are applied → no state change. Asynchronous reset between edges → issue_valid = 0 immediately, all entries FREE.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: tag/data widths, station entry layout and
// helpers to unpack and search the serialized common data bus.
package tomasulo_pkg;

    localparam int TAG_W     = 8;
    localparam int DATA_W    = 32;
    localparam int CDB_LANES = 4;
    localparam int OP_W      = 4;

    typedef enum logic [1:0] {
        FREE,
        WAIT,
        READY,
        ISSUED
    } rs_state_t;

    // p1/p2 set means v1/v2 still hold a producer tag in the low bits
    typedef struct packed {
        rs_state_t           state;
        logic [OP_W-1:0]     op;
        logic [DATA_W-1:0]   v1;
        logic [DATA_W-1:0]   v2;
        logic                p1;
        logic                p2;
    } rs_entry_t;

    typedef struct packed {
        logic [CDB_LANES-1:0][TAG_W-1:0]  tag;
        logic [CDB_LANES-1:0][DATA_W-1:0] data;
    } cdb_t;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } cdb_hit_t;

    // Lane 0 sits in the most significant slice of each serialized bus
    function automatic cdb_t cdb_unpack(
        input logic [CDB_LANES*DATA_W-1:0] data_ser,
        input logic [CDB_LANES*TAG_W-1:0]  tag_ser
    );
        cdb_t c;
        for (int i = 0; i < CDB_LANES; i++) begin
            c.tag[i]  = tag_ser[(CDB_LANES-i)*TAG_W-1 -: TAG_W];
            c.data[i] = data_ser[(CDB_LANES-i)*DATA_W-1 -: DATA_W];
        end
        return c;
    endfunction

    // Idle lanes carry tag 0; on multiple hits the highest lane wins
    function automatic cdb_hit_t cdb_lookup(
        input cdb_t             c,
        input logic [TAG_W-1:0] tag
    );
        cdb_hit_t r;
        r = '0;
        for (int i = 0; i < CDB_LANES; i++) begin
            if (c.tag[i] != '0 && c.tag[i] == tag) begin
                r.hit  = 1'b1;
                r.data = c.data[i];
            end
        end
        return r;
    endfunction

    function automatic logic tag_on_cdb(
        input cdb_t             c,
        input logic [TAG_W-1:0] tag
    );
        cdb_hit_t h;
        h = cdb_lookup(c, tag);
        return h.hit;
    endfunction

endpackage

// File: rtl/rs_priority_pick.sv
// Lowest-set-bit finder used for free-slot allocation and issue
// selection inside the reservation station.
module rs_priority_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx,
    output logic         found
);

    // Scan downward so the lowest requesting index is written last
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Dual-dispatch reservation station: holds renamed instructions, snoops
// the CDB for pending operands and issues ready work to one FU.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STATION_ID = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        disp_valid_A,
    input  logic [OP_W-1:0]             disp_op_A,
    input  logic [DATA_W-1:0]           disp_v1_A,
    input  logic [DATA_W-1:0]           disp_v2_A,
    input  logic                        disp_t1_A,
    input  logic                        disp_t2_A,
    input  logic                        disp_valid_B,
    input  logic [OP_W-1:0]             disp_op_B,
    input  logic [DATA_W-1:0]           disp_v1_B,
    input  logic [DATA_W-1:0]           disp_v2_B,
    input  logic                        disp_t1_B,
    input  logic                        disp_t2_B,
    output logic [TAG_W-1:0]            alloc_tag_A,
    output logic [TAG_W-1:0]            alloc_tag_B,
    output logic                        alloc_ok_A,
    output logic                        alloc_ok_B,
    input  logic [CDB_LANES*DATA_W-1:0] CDB_data_serialized,
    input  logic [CDB_LANES*TAG_W-1:0]  CDB_tag_serialized,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [OP_W-1:0]             issue_op,
    output logic [DATA_W-1:0]           issue_src1,
    output logic [DATA_W-1:0]           issue_src2,
    output logic [TAG_W-1:0]            issue_tag
);

    localparam logic [4:0]       SID      = 5'(STATION_ID);
    localparam logic [TAG_W-1:0] BASE_TAG = {SID, 3'd0};

    rs_entry_t        entry_q [DEPTH];
    rs_entry_t        entry_d [DEPTH];
    cdb_t             cdb;
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] free_mask;
    logic [DEPTH-1:0] ready_vec;
    logic [2:0]       free_idx_a;
    logic [2:0]       free_idx_b;
    logic [2:0]       ready_idx;
    logic             free_found_a;
    logic             free_found_b;
    logic             ready_found;
    logic             fire_a;
    logic             fire_b;
    logic             fire_issue;

    // Tag operands are zero-extended; a same-cycle CDB hit forwards data
    function automatic rs_entry_t make_entry(
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] v1,
        input logic              t1,
        input logic [DATA_W-1:0] v2,
        input logic              t2,
        input cdb_t              c
    );
        rs_entry_t e;
        cdb_hit_t  h1;
        cdb_hit_t  h2;
        h1   = cdb_lookup(c, v1[TAG_W-1:0]);
        h2   = cdb_lookup(c, v2[TAG_W-1:0]);
        e.op = op;
        e.p1 = t1 && !h1.hit;
        e.p2 = t2 && !h2.hit;
        e.v1 = !t1 ? v1 : (h1.hit ? h1.data
             : {{(DATA_W-TAG_W){1'b0}}, v1[TAG_W-1:0]});
        e.v2 = !t2 ? v2 : (h2.hit ? h2.data
             : {{(DATA_W-TAG_W){1'b0}}, v2[TAG_W-1:0]});
        e.state = (e.p1 || e.p2) ? WAIT : READY;
        return e;
    endfunction

    // Capture broadcast results into pending operands of a waiting entry
    function automatic rs_entry_t capture(
        input rs_entry_t e,
        input cdb_t      c
    );
        rs_entry_t r;
        cdb_hit_t  h1;
        cdb_hit_t  h2;
        r  = e;
        h1 = cdb_lookup(c, e.v1[TAG_W-1:0]);
        h2 = cdb_lookup(c, e.v2[TAG_W-1:0]);
        if (e.p1 && h1.hit) begin
            r.v1 = h1.data;
            r.p1 = 1'b0;
        end
        if (e.p2 && h2.hit) begin
            r.v2 = h2.data;
            r.p2 = 1'b0;
        end
        if (!r.p1 && !r.p2) begin
            r.state = READY;
        end
        return r;
    endfunction

    assign cdb = cdb_unpack(CDB_data_serialized, CDB_tag_serialized);

    // Occupancy vectors seen by the allocation and issue pickers
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i]  = (entry_q[i].state == FREE);
            ready_vec[i] = (entry_q[i].state == READY);
        end
    end

    // Hide port A's slot so the second picker finds the next free one
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            free_mask[i] = free_vec[i]
                && !(free_found_a && free_idx_a == 3'(i));
        end
    end

    rs_priority_pick #(.N(DEPTH)) u_pick_free_a (
        .req   (free_vec),
        .idx   (free_idx_a),
        .found (free_found_a)
    );

    rs_priority_pick #(.N(DEPTH)) u_pick_free_b (
        .req   (free_mask),
        .idx   (free_idx_b),
        .found (free_found_b)
    );

    rs_priority_pick #(.N(DEPTH)) u_pick_ready (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    assign alloc_ok_A  = free_found_a;
    assign alloc_ok_B  = free_found_b;
    assign alloc_tag_A = free_found_a ? {SID, free_idx_a} : BASE_TAG;
    assign alloc_tag_B = free_found_b ? {SID, free_idx_b} : BASE_TAG;

    assign fire_a      = en && disp_valid_A && free_found_a;
    assign fire_b      = en && disp_valid_B && free_found_b;
    assign issue_valid = en && ready_found;
    assign fire_issue  = issue_valid && issue_ready;

    // Present the lowest-index ready entry to the functional unit
    always_comb begin
        issue_op   = '0;
        issue_src1 = '0;
        issue_src2 = '0;
        issue_tag  = BASE_TAG;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_found && ready_idx == 3'(i)) begin
                issue_op   = entry_q[i].op;
                issue_src1 = entry_q[i].v1;
                issue_src2 = entry_q[i].v2;
                issue_tag  = {SID, 3'(i)};
            end
        end
    end

    // Per-entry lifecycle plus dispatch writes into free slots
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            unique case (entry_q[i].state)
                FREE: begin
                end
                WAIT: begin
                    entry_d[i] = capture(entry_q[i], cdb);
                end
                READY: begin
                    if (fire_issue && ready_idx == 3'(i)) begin
                        entry_d[i].state = ISSUED;
                    end
                end
                ISSUED: begin
                    if (tag_on_cdb(cdb, {SID, 3'(i)})) begin
                        entry_d[i].state = FREE;
                    end
                end
            endcase
            if (fire_a && free_idx_a == 3'(i)) begin
                entry_d[i] = make_entry(disp_op_A, disp_v1_A, disp_t1_A,
                                        disp_v2_A, disp_t2_A, cdb);
            end
            if (fire_b && free_idx_b == 3'(i)) begin
                entry_d[i] = make_entry(disp_op_B, disp_v1_B, disp_t1_B,
                                        disp_v2_B, disp_t2_B, cdb);
            end
        end
    end

    // Entry storage; en low freezes everything, reset empties the station
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule
